ps2_rx: RTL and testbench

Receives serial frames from a PS/2 keyboard or mouse and presents each validated data byte on a parallel output with a single-cycle strobe. It sits between the board-level PS/2 clock and data pins and the keyboard decoding logic. The clock and data lines are synchronised and de-glitched. Each frame is checked for parity and stop bit, and a watchdog recovers from stalled frames.

---
 rtl/ps2_rx.sv | 119 +++++++++++
 tb/tb_ps2_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 serial receiver: synchronises and de-glitches ps2c/ps2d, frames 11-bit
// words, checks odd parity and stop bit, and strobes each valid byte out.
module ps2_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2d,
   input  logic       ps2c,
   input  logic       rx_en,
   output logic       rx_done_tick,
   output logic [7:0] dout
);

   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

   logic                  ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
   logic [FILTER_LEN-1:0] filter_q, filter_d;
   logic                  filt_q, filt_d;
   logic                  fall_edge;

   state_t                state_q, state_d;
   logic [9:0]            shift_q, shift_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [WDOG_W-1:0]     wdog_q, wdog_d;
   logic [7:0]            dout_q, dout_d;
   logic                  tick_q, tick_d;

   // Filtered level only moves when the whole sample window agrees.
   always_comb begin
      filter_d = {ps2c_s2_q, filter_q[FILTER_LEN-1:1]};
      filt_d   = filt_q;
      if (&filter_q)
         filt_d = 1'b1;
      else if (~|filter_q)
         filt_d = 1'b0;
      fall_edge = filt_q & ~filt_d;
   end

   // The frame check is folded into the stop-bit edge so the tick is a
   // registered output that is high during the CHECK cycle itself.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      wdog_d    = wdog_q;
      dout_d    = dout_q;
      tick_d    = 1'b0;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (fall_edge && rx_en && !ps2d_s2_q) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (fall_edge) begin
               shift_d   = {ps2d_s2_q, shift_q[9:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               wdog_d    = '0;
               if (bit_cnt_q == 4'd9) begin
                  state_d = CHECK;
                  if ((^shift_d[8:0]) && shift_d[9]) begin
                     dout_d = shift_d[7:0];
                     tick_d = 1'b1;
                  end
               end
            end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = IDLE;
               wdog_d  = '0;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         CHECK: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps2c_s1_q <= 1'b0;
         ps2c_s2_q <= 1'b0;
         ps2d_s1_q <= 1'b0;
         ps2d_s2_q <= 1'b0;
         filter_q  <= '0;
         filt_q    <= 1'b0;
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         wdog_q    <= '0;
         dout_q    <= 8'h00;
         tick_q    <= 1'b0;
      end else begin
         ps2c_s1_q <= ps2c;
         ps2c_s2_q <= ps2c_s1_q;
         ps2d_s1_q <= ps2d;
         ps2d_s2_q <= ps2d_s1_q;
         filter_q  <= filter_d;
         filt_q    <= filt_d;
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         wdog_q    <= wdog_d;
         dout_q    <= dout_d;
         tick_q    <= tick_d;
      end
   end

   assign rx_done_tick = tick_q;
   assign dout         = dout_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: table of whole frames plus hand-built corner cases, with a
// scoreboard queue of expected bytes popped on every rx_done_tick.
module tb_ps2_rx;

   localparam int HALF    = 40;
   localparam int TIMEOUT = 400;
   localparam int LATENCY = 11;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2d = 1'b1;
   logic       ps2c = 1'b1;
   logic       rx_en = 1'b1;
   logic       rx_done_tick;
   logic [7:0] dout;

   int         pass_cnt = 0;
   int         total_cnt = 0;
   int         tick_cnt = 0;
   int         cyc = 0;
   int         stop_cyc = 0;
   logic       prev_tick = 1'b0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      bit         bad_par;
      bit         stop;
      bit         en;
      logic [7:0] exp_dout;
      int         exp_ticks;
   } vec_t;

   vec_t vecs[8];

   ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .ps2d         (ps2d),
      .ps2c         (ps2c),
      .rx_en        (rx_en),
      .rx_done_tick (rx_done_tick),
      .dout         (dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total_cnt++;
      if (actual == expected)
         pass_cnt++;
      else
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every tick must match the oldest expected byte.
   always @(negedge clk) begin
      if (prev_tick)
         checkOutput("tick_width", int'(rx_done_tick), 0);
      if (rx_done_tick) begin
         tick_cnt++;
         checkOutput("tick_latency", cyc - stop_cyc, LATENCY);
         if (exp_q.size() == 0)
            checkOutput("unexpected_tick_dout", int'(dout), -1);
         else
            checkOutput("sb_dout", int'(dout), int'(exp_q.pop_front()));
      end
      prev_tick = rx_done_tick;
   end

   task automatic applyStimulus(input logic [7:0] data, input bit bad_par, input bit stop,
                                input int nbits, input bit glitch, input int en_off_at,
                                input bit expect_valid);
      logic [10:0] bits;
      bits = {stop, (~^data) ^ bad_par, data, 1'b0};
      if (expect_valid)
         exp_q.push_back(data);
      for (int i = 0; i < nbits; i++) begin
         if (i == en_off_at)
            rx_en = 1'b0;
         ps2d = bits[i];
         if (glitch) begin
            wait_cycles(20);
            ps2c = 1'b0;
            wait_cycles(3);
            ps2c = 1'b1;
            wait_cycles(HALF - 23);
         end else begin
            wait_cycles(HALF);
         end
         ps2c = 1'b0;
         if (i == 10)
            stop_cyc = cyc;
         wait_cycles(HALF);
         ps2c = 1'b1;
      end
      ps2d = 1'b1;
   endtask

   initial begin
      int t0;
      vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h00, 0};
      vecs[1] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1};
      vecs[2] = '{8'h5A, 1'b0, 1'b1, 1'b0, 8'h1C, 0};
      vecs[3] = '{8'hF0, 1'b0, 1'b1, 1'b1, 8'hF0, 1};
      vecs[4] = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1};
      vecs[5] = '{8'h33, 1'b0, 1'b0, 1'b1, 8'h5A, 0};
      vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1};
      vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1};

      wait_cycles(3);
      @(negedge clk);
      checkOutput("reset_dout", int'(dout), 8'h00);
      checkOutput("reset_tick", int'(rx_done_tick), 0);
      reset = 1'b1;
      wait_cycles(20);

      for (int i = 0; i < 8; i++) begin
         rx_en = vecs[i].en;
         t0 = tick_cnt;
         applyStimulus(vecs[i].data, vecs[i].bad_par, vecs[i].stop, 11, 1'b0, -1,
                       vecs[i].en && !vecs[i].bad_par && vecs[i].stop);
         wait_cycles(30);
         checkOutput($sformatf("vec%0d_dout", i), int'(dout), int'(vecs[i].exp_dout));
         checkOutput($sformatf("vec%0d_ticks", i), tick_cnt - t0, vecs[i].exp_ticks);
      end
      rx_en = 1'b1;

      // Glitches on the high phase of every bit must not create extra edges.
      t0 = tick_cnt;
      applyStimulus(8'h29, 1'b0, 1'b1, 11, 1'b1, -1, 1'b1);
      wait_cycles(30);
      checkOutput("glitch_dout", int'(dout), 8'h29);
      checkOutput("glitch_ticks", tick_cnt - t0, 1);

      // Stalled frame is dropped by the watchdog before the next frame.
      t0 = tick_cnt;
      applyStimulus(8'hA5, 1'b0, 1'b1, 5, 1'b0, -1, 1'b0);
      wait_cycles(TIMEOUT + 200);
      applyStimulus(8'h1C, 1'b0, 1'b1, 11, 1'b0, -1, 1'b1);
      wait_cycles(30);
      checkOutput("timeout_dout", int'(dout), 8'h1C);
      checkOutput("timeout_ticks", tick_cnt - t0, 1);

      // Dropping rx_en mid-frame still completes the frame.
      t0 = tick_cnt;
      applyStimulus(8'h77, 1'b0, 1'b1, 11, 1'b0, 3, 1'b1);
      wait_cycles(30);
      checkOutput("en_drop_dout", int'(dout), 8'h77);
      checkOutput("en_drop_ticks", tick_cnt - t0, 1);
      rx_en = 1'b1;

      t0 = tick_cnt;
      applyStimulus(8'h99, 1'b0, 1'b1, 6, 1'b0, -1, 1'b0);
      reset = 1'b0;
      wait_cycles(5);
      @(negedge clk);
      checkOutput("midreset_dout", int'(dout), 8'h00);
      checkOutput("midreset_tick", int'(rx_done_tick), 0);
      reset = 1'b1;
      wait_cycles(20);
      applyStimulus(8'h45, 1'b0, 1'b1, 11, 1'b0, -1, 1'b1);
      wait_cycles(30);
      checkOutput("after_reset_dout", int'(dout), 8'h45);
      checkOutput("after_reset_ticks", tick_cnt - t0, 1);

      checkOutput("sb_leftover", exp_q.size(), 0);
      $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
